// File: rtl/sync_updown_counter.sv
// sync_updown_counter
// Parametrised synchronous up/down counter with modulus, parallel load with
// clamp, combinational terminal count and a registered overflow pulse.
// Optional feature macro: SYNC_CNT_SAT_EN -- when defined the counter
// saturates at its limits instead of wrapping (ovf still pulses on each
// attempted step past a limit).
module sync_updown_counter #(
   parameter int     WIDTH     = 3,
   parameter longint MODULUS   = 8,
   parameter longint RESET_VAL = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             ovf
);

   // MODULUS may be 2**WIDTH, so the limits are computed wide and then cut down.
   localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VAL);
   localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

   logic [WIDTH-1:0] r_q;
   logic             r_ovf;
   logic             w_at_max;
   logic             w_at_min;
   logic [WIDTH-1:0] w_load_val;

   // Limit detection and load clamping.
   always_comb begin
      w_at_max   = (r_q == MAX_VAL);
      w_at_min   = (r_q == '0);
      w_load_val = (din > MAX_VAL) ? MAX_VAL : din;
   end

   // Count state: rst > load > en > hold; ovf pulses only on a limit step.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_q   <= RST_VAL;
         r_ovf <= 1'b0;
      end else if (load) begin
         r_q   <= w_load_val;
         r_ovf <= 1'b0;
      end else if (en) begin
         if (up) begin
            if (w_at_max) begin
`ifdef SYNC_CNT_SAT_EN
               r_q <= MAX_VAL;
`else
               r_q <= '0;
`endif
               r_ovf <= 1'b1;
            end else begin
               r_q   <= r_q + ONE;
               r_ovf <= 1'b0;
            end
         end else begin
            if (w_at_min) begin
`ifdef SYNC_CNT_SAT_EN
               r_q <= '0;
`else
               r_q <= MAX_VAL;
`endif
               r_ovf <= 1'b1;
            end else begin
               r_q   <= r_q - ONE;
               r_ovf <= 1'b0;
            end
         end
      end else begin
         r_ovf <= 1'b0;
      end
   end

   // Terminal count is zero-latency so it can enable the next cascaded stage.
   always_comb begin
      tc = en & ~load & (up ? w_at_max : w_at_min);
   end

   assign q   = r_q;
   assign ovf = r_ovf;

endmodule

// File: tb/tb_sync_updown_counter.sv
// tb_sync_updown_counter
// Directed bench for sync_updown_counter: default build checks wrap-around,
// SYNC_CNT_SAT_EN build checks saturation.
module tb_sync_updown_counter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   // a: default params
   logic a_en, a_up, a_load, a_tc, a_ovf;
   logic [2:0] a_din, a_q;
   // b: WIDTH=4 MODULUS=10
   logic b_en, b_up, b_load, b_tc, b_ovf;
   logic [3:0] b_din, b_q;
   // c: RESET_VAL=3
   logic c_en, c_up, c_load, c_tc, c_ovf;
   logic [2:0] c_din, c_q;
   // cascade pair
   logic d_en;
   logic [2:0] lo_q, hi_q;
   logic lo_tc, lo_ovf, hi_tc, hi_ovf;

   int n_pass = 0;
   int n_total = 0;

   sync_updown_counter u_a (
      .clk(clk), .rst(rst), .en(a_en), .up(a_up), .load(a_load), .din(a_din),
      .q(a_q), .tc(a_tc), .ovf(a_ovf));

   sync_updown_counter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) u_b (
      .clk(clk), .rst(rst), .en(b_en), .up(b_up), .load(b_load), .din(b_din),
      .q(b_q), .tc(b_tc), .ovf(b_ovf));

   sync_updown_counter #(.WIDTH(3), .MODULUS(8), .RESET_VAL(3)) u_c (
      .clk(clk), .rst(rst), .en(c_en), .up(c_up), .load(c_load), .din(c_din),
      .q(c_q), .tc(c_tc), .ovf(c_ovf));

   sync_updown_counter u_lo (
      .clk(clk), .rst(rst), .en(d_en), .up(1'b1), .load(1'b0), .din(3'd0),
      .q(lo_q), .tc(lo_tc), .ovf(lo_ovf));

   sync_updown_counter u_hi (
      .clk(clk), .rst(rst), .en(lo_tc), .up(1'b1), .load(1'b0), .din(3'd0),
      .q(hi_q), .tc(hi_tc), .ovf(hi_ovf));

   task automatic step;
      @(posedge clk);
      #1;
      $display("t=%0t rst=%0b a_q=%0d a_ovf=%0b b_q=%0d b_ovf=%0b c_q=%0d cas=%0d hi_ovf=%0b",
               $time, rst, a_q, a_ovf, b_q, b_ovf, c_q, {hi_q, lo_q}, hi_ovf);
   endtask

   task automatic pulse_reset;
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      a_en = 0; a_up = 1; a_load = 0; a_din = 0;
      b_en = 0; b_up = 1; b_load = 0; b_din = 0;
      c_en = 0; c_up = 1; c_load = 0; c_din = 0;
      d_en = 0;
      step();
      step();
      n_total++; if (a_q !== 3'd0) $display("FAIL reset_a_q: got %0d expected 0", a_q); else n_pass++;
      n_total++; if (a_ovf !== 1'b0) $display("FAIL reset_a_ovf: got %0b expected 0", a_ovf); else n_pass++;
      n_total++; if (a_tc !== 1'b0) $display("FAIL reset_a_tc: got %0b expected 0", a_tc); else n_pass++;
      n_total++; if (b_q !== 4'd0) $display("FAIL reset_b_q: got %0d expected 0", b_q); else n_pass++;
      n_total++; if (c_q !== 3'd3) $display("FAIL reset_c_q: got %0d expected 3", c_q); else n_pass++;
      n_total++; if ({hi_q, lo_q} !== 6'd0) $display("FAIL reset_cascade_q: got %0d expected 0", {hi_q, lo_q}); else n_pass++;
      rst = 1'b0;
   endtask

`ifndef SYNC_CNT_SAT_EN
   task automatic test_up_wrap;
      int q_tab [9]   = '{1, 2, 3, 4, 5, 6, 7, 0, 1};
      bit ovf_tab [9] = '{0, 0, 0, 0, 0, 0, 0, 1, 0};
      bit tc_tab [9]  = '{0, 0, 0, 0, 0, 0, 0, 1, 0};
      a_en = 1; a_up = 1;
      for (int i = 0; i < 9; i++) begin
         #1;
         n_total++; if (a_tc !== tc_tab[i]) $display("FAIL up_wrap_tc[%0d]: got %0b expected %0b", i, a_tc, tc_tab[i]); else n_pass++;
         step();
         n_total++; if (a_q !== 3'(q_tab[i])) $display("FAIL up_wrap_q[%0d]: got %0d expected %0d", i, a_q, q_tab[i]); else n_pass++;
         n_total++; if (a_ovf !== ovf_tab[i]) $display("FAIL up_wrap_ovf[%0d]: got %0b expected %0b", i, a_ovf, ovf_tab[i]); else n_pass++;
      end
      a_en = 0;
   endtask

   task automatic test_down_wrap;
      int q_tab [11]   = '{9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 9};
      bit ovf_tab [11] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
      bit tc_tab [11]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
      b_en = 1; b_up = 0;
      for (int i = 0; i < 11; i++) begin
         #1;
         n_total++; if (b_tc !== tc_tab[i]) $display("FAIL down_wrap_tc[%0d]: got %0b expected %0b", i, b_tc, tc_tab[i]); else n_pass++;
         step();
         n_total++; if (b_q !== 4'(q_tab[i])) $display("FAIL down_wrap_q[%0d]: got %0d expected %0d", i, b_q, q_tab[i]); else n_pass++;
         n_total++; if (b_ovf !== ovf_tab[i]) $display("FAIL down_wrap_ovf[%0d]: got %0b expected %0b", i, b_ovf, ovf_tab[i]); else n_pass++;
      end
      b_en = 0; b_up = 1;
   endtask

   task automatic test_cascade;
      int exp_v;
      pulse_reset();
      d_en = 1;
      for (int k = 0; k < 64; k++) begin
         step();
         exp_v = (k + 1) % 64;
         n_total++; if ({hi_q, lo_q} !== 6'(exp_v)) $display("FAIL cascade_q[%0d]: got %0d expected %0d", k, {hi_q, lo_q}, exp_v); else n_pass++;
         n_total++; if (hi_ovf !== (k == 63)) $display("FAIL cascade_hi_ovf[%0d]: got %0b expected %0b", k, hi_ovf, (k == 63)); else n_pass++;
         n_total++; if (lo_ovf !== (exp_v % 8 == 0)) $display("FAIL cascade_lo_ovf[%0d]: got %0b expected %0b", k, lo_ovf, (exp_v % 8 == 0)); else n_pass++;
      end
      d_en = 0;
      step();
      n_total++; if ({hi_q, lo_q} !== 6'd0) $display("FAIL cascade_hold_q: got %0d expected 0", {hi_q, lo_q}); else n_pass++;
      n_total++; if (hi_ovf !== 1'b0) $display("FAIL cascade_hold_ovf: got %0b expected 0", hi_ovf); else n_pass++;
   endtask
`else
   task automatic test_saturate;
      int q_tab [10]   = '{1, 2, 3, 4, 5, 6, 7, 7, 7, 7};
      bit ovf_tab [10] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1};
      bit tc_tab [10]  = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1};
      pulse_reset();
      a_en = 1; a_up = 1;
      for (int i = 0; i < 10; i++) begin
         #1;
         n_total++; if (a_tc !== tc_tab[i]) $display("FAIL sat_up_tc[%0d]: got %0b expected %0b", i, a_tc, tc_tab[i]); else n_pass++;
         step();
         n_total++; if (a_q !== 3'(q_tab[i])) $display("FAIL sat_up_q[%0d]: got %0d expected %0d", i, a_q, q_tab[i]); else n_pass++;
         n_total++; if (a_ovf !== ovf_tab[i]) $display("FAIL sat_up_ovf[%0d]: got %0b expected %0b", i, a_ovf, ovf_tab[i]); else n_pass++;
      end
      a_up = 0;
      step();
      n_total++; if (a_q !== 3'd6) $display("FAIL sat_turn_q: got %0d expected 6", a_q); else n_pass++;
      n_total++; if (a_ovf !== 1'b0) $display("FAIL sat_turn_ovf: got %0b expected 0", a_ovf); else n_pass++;
      a_en = 0; a_up = 1;
      // b sits at 0 after reset: downward steps must stick at 0 with ovf.
      b_en = 1; b_up = 0;
      #1;
      n_total++; if (b_tc !== 1'b1) $display("FAIL sat_down_tc: got %0b expected 1", b_tc); else n_pass++;
      step();
      n_total++; if (b_q !== 4'd0) $display("FAIL sat_down_q: got %0d expected 0", b_q); else n_pass++;
      n_total++; if (b_ovf !== 1'b1) $display("FAIL sat_down_ovf: got %0b expected 1", b_ovf); else n_pass++;
      b_en = 0; b_up = 1;
   endtask
`endif

   task automatic test_load;
`ifdef SYNC_CNT_SAT_EN
      logic [3:0] exp_after_max = 4'd9;
`else
      logic [3:0] exp_after_max = 4'd0;
`endif
      // out-of-range load clamps to MODULUS-1
      b_load = 1; b_din = 4'd12; b_en = 0;
      #1;
      n_total++; if (b_tc !== 1'b0) $display("FAIL load_tc_noen: got %0b expected 0", b_tc); else n_pass++;
      step();
      n_total++; if (b_q !== 4'd9) $display("FAIL load_clamp_q: got %0d expected 9", b_q); else n_pass++;
      n_total++; if (b_ovf !== 1'b0) $display("FAIL load_clamp_ovf: got %0b expected 0", b_ovf); else n_pass++;
      // at q=9 counting up raises tc, but a simultaneous load masks it and wins
      b_load = 0; b_en = 1; b_up = 1;
      #1;
      n_total++; if (b_tc !== 1'b1) $display("FAIL tc_at_max: got %0b expected 1", b_tc); else n_pass++;
      b_load = 1; b_din = 4'd5;
      #1;
      n_total++; if (b_tc !== 1'b0) $display("FAIL tc_masked_by_load: got %0b expected 0", b_tc); else n_pass++;
      step();
      n_total++; if (b_q !== 4'd5) $display("FAIL load_wins_q: got %0d expected 5", b_q); else n_pass++;
      n_total++; if (b_ovf !== 1'b0) $display("FAIL load_wins_ovf: got %0b expected 0", b_ovf); else n_pass++;
      // load exactly MODULUS-1, then step past the limit
      b_din = 4'd9; b_en = 0;
      step();
      n_total++; if (b_q !== 4'd9) $display("FAIL load_max_q: got %0d expected 9", b_q); else n_pass++;
      b_load = 0; b_en = 1; b_up = 1;
      step();
      n_total++; if (b_q !== exp_after_max) $display("FAIL step_past_max_q: got %0d expected %0d", b_q, exp_after_max); else n_pass++;
      n_total++; if (b_ovf !== 1'b1) $display("FAIL step_past_max_ovf: got %0b expected 1", b_ovf); else n_pass++;
      // load while ovf is high clears it
      b_load = 1; b_din = 4'd3;
      step();
      n_total++; if (b_q !== 4'd3) $display("FAIL load_after_ovf_q: got %0d expected 3", b_q); else n_pass++;
      n_total++; if (b_ovf !== 1'b0) $display("FAIL load_after_ovf_ovf: got %0b expected 0", b_ovf); else n_pass++;
      b_load = 0; b_en = 0;
      step();
      n_total++; if (b_q !== 4'd3) $display("FAIL hold_q: got %0d expected 3", b_q); else n_pass++;
   endtask

   task automatic test_reset_mid;
      pulse_reset();
      a_en = 1; a_up = 1; c_up = 1;
      for (int i = 0; i < 5; i++) begin
         c_en = (i < 2);
         step();
      end
      n_total++; if (a_q !== 3'd5) $display("FAIL mid_a_count: got %0d expected 5", a_q); else n_pass++;
      n_total++; if (c_q !== 3'd5) $display("FAIL mid_c_count: got %0d expected 5", c_q); else n_pass++;
      rst = 1; a_load = 1; a_din = 3'd2; c_en = 1; c_load = 1; c_din = 3'd6;
      step();
      n_total++; if (a_q !== 3'd0) $display("FAIL mid_rst_a_q: got %0d expected 0", a_q); else n_pass++;
      n_total++; if (a_ovf !== 1'b0) $display("FAIL mid_rst_a_ovf: got %0b expected 0", a_ovf); else n_pass++;
      n_total++; if (c_q !== 3'd3) $display("FAIL mid_rst_c_q: got %0d expected 3", c_q); else n_pass++;
      rst = 0; a_load = 0; c_load = 0;
      for (int i = 0; i < 7; i++) begin
         c_en = (i < 4);
         step();
      end
      n_total++; if (a_q !== 3'd7) $display("FAIL pre_wrap_a_q: got %0d expected 7", a_q); else n_pass++;
      n_total++; if (c_q !== 3'd7) $display("FAIL pre_wrap_c_q: got %0d expected 7", c_q); else n_pass++;
      // reset lands on the edge that would otherwise wrap: no ovf
      rst = 1; c_en = 1;
      step();
      n_total++; if (a_q !== 3'd0) $display("FAIL rst_drop_a_q: got %0d expected 0", a_q); else n_pass++;
      n_total++; if (a_ovf !== 1'b0) $display("FAIL rst_drop_a_ovf: got %0b expected 0", a_ovf); else n_pass++;
      n_total++; if (c_q !== 3'd3) $display("FAIL rst_drop_c_q: got %0d expected 3", c_q); else n_pass++;
      n_total++; if (c_ovf !== 1'b0) $display("FAIL rst_drop_c_ovf: got %0b expected 0", c_ovf); else n_pass++;
      rst = 0; a_en = 0; c_en = 0;
      step();
   endtask

   initial begin
      rst = 1'b1;
      @(posedge clk);
      #1;
      test_reset();
`ifndef SYNC_CNT_SAT_EN
      test_up_wrap();
      test_down_wrap();
`else
      test_saturate();
`endif
      test_load();
      test_reset_mid();
`ifndef SYNC_CNT_SAT_EN
      test_cascade();
`endif
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
